// File: rtl/tcp_gen.sv
// tcp_gen: TCP segment generator on a 32-bit valid/ready word stream.
//
// On an accepted start (IDLE only) it emits a 5-word TCP header followed by
// an incrementing-count payload of n = min(payload_words, MAX_WORDS) words.
// One valid-low GAP cycle carrying a done pulse follows each segment.
//
// Optional feature macro: TCP_GEN_CSUM_EN
//   defined     : header word 4 carries the inverted ones'-complement sum
//                 of the W0..W3 halves plus URG_PTR (header-only check value)
//   not defined : checksum field is zero and no adder is built
//
// Ports:
//   clk             in   clock
//   reset           in   synchronous, active-high reset
//   start           in   request one segment (ignored unless IDLE)
//   payload_words   in   payload length in words, sampled on accept
//   flags           in   TCP flag byte, sampled on accept
//   tcp_data_out    out  stream data (registered)
//   tcp_data_valid  out  stream valid (registered)
//   tcp_data_ready  in   sink ready
//   busy            out  segment in progress (HEADER, DATA, GAP)
//   done            out  one-cycle pulse in the GAP cycle
module tcp_gen #(
  parameter logic [15:0] SRC_PORT  = 16'h0400,
  parameter logic [15:0] DES_PORT  = 16'h00aa,
  parameter logic [31:0] SEQ_NUM   = 32'h55bc55bc,
  parameter logic [31:0] ACK_NUM   = 32'hbc55bc55,
  parameter logic [15:0] URG_PTR   = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'd16378
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] payload_words,
  input  logic [7:0]  flags,
  output logic [31:0] tcp_data_out,
  output logic        tcp_data_valid,
  input  logic        tcp_data_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  hc_q, hc_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] n_q, n_d;
  logic [7:0]  flags_q, flags_d;
  logic [15:0] len_q, len_d;
  logic [15:0] csum_q, csum_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] n_acc;
  logic [15:0] len_acc;
  logic        handshake;

  function automatic logic [31:0] hdr_word(input logic [2:0]  idx,
                                           input logic [7:0]  fl,
                                           input logic [15:0] ln,
                                           input logic [15:0] cs);
    case (idx)
      3'd0:    hdr_word = {SRC_PORT, DES_PORT};
      3'd1:    hdr_word = SEQ_NUM;
      3'd2:    hdr_word = ACK_NUM;
      3'd3:    hdr_word = {4'h5, 4'h0, fl, ln};
      default: hdr_word = {cs, URG_PTR};
    endcase
  endfunction

`ifdef TCP_GEN_CSUM_EN
  // Nine 16-bit terms fit in 20 bits; after the first fold the low half is
  // tiny whenever a carry remains, so a second fold cannot carry again.
  function automatic logic [15:0] hdr_csum(input logic [7:0]  fl,
                                           input logic [15:0] ln);
    logic [19:0] acc;
    logic [16:0] fold;
    acc = 20'(SRC_PORT) + 20'(DES_PORT) +
          20'(SEQ_NUM[31:16]) + 20'(SEQ_NUM[15:0]) +
          20'(ACK_NUM[31:16]) + 20'(ACK_NUM[15:0]) +
          20'({8'h50, fl}) + 20'(ln) + 20'(URG_PTR);
    fold = 17'(acc[15:0]) + 17'(acc[19:16]);
    hdr_csum = ~(fold[15:0] + 16'(fold[16]));
  endfunction
`endif

  assign n_acc     = (payload_words > MAX_WORDS) ? MAX_WORDS : payload_words;
  assign len_acc   = 16'd20 + {n_acc[13:0], 2'b00};
  assign handshake = valid_q & tcp_data_ready;

  // Next-state and next-output logic. The output register always holds the
  // word being presented; a new word is loaded only on a handshake, which
  // keeps data stable under backpressure.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    pc_d    = pc_q;
    n_d     = n_q;
    flags_d = flags_q;
    len_d   = len_q;
    csum_d  = csum_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        data_d  = 32'h0;
        busy_d  = 1'b0;
        if (start) begin
          n_d     = n_acc;
          flags_d = flags;
          len_d   = len_acc;
`ifdef TCP_GEN_CSUM_EN
          csum_d  = hdr_csum(flags, len_acc);
`else
          csum_d  = 16'h0000;
`endif
          hc_d    = 3'd0;
          pc_d    = 16'd0;
          data_d  = {SRC_PORT, DES_PORT};
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = HEADER;
        end
      end

      HEADER: begin
        if (handshake) begin
          if (hc_q == 3'd4) begin
            hc_d = 3'd0;
            if (n_q != 16'd0) begin
              pc_d    = 16'd0;
              data_d  = 32'h0;
              state_d = DATA;
            end else begin
              valid_d = 1'b0;
              data_d  = 32'h0;
              done_d  = 1'b1;
              state_d = GAP;
            end
          end else begin
            hc_d   = hc_q + 3'd1;
            data_d = hdr_word(hc_q + 3'd1, flags_q, len_q, csum_q);
          end
        end
      end

      DATA: begin
        if (handshake) begin
          if (pc_q == n_q - 16'd1) begin
            pc_d    = 16'd0;
            valid_d = 1'b0;
            data_d  = 32'h0;
            done_d  = 1'b1;
            state_d = GAP;
          end else begin
            pc_d   = pc_q + 16'd1;
            data_d = {16'h0000, pc_q + 16'd1};
          end
        end
      end

      default: begin
        valid_d = 1'b0;
        data_d  = 32'h0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hc_q    <= 3'd0;
      pc_q    <= 16'd0;
      n_q     <= 16'd0;
      flags_q <= 8'd0;
      len_q   <= 16'd0;
      csum_q  <= 16'd0;
      data_q  <= 32'h0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      pc_q    <= pc_d;
      n_q     <= n_d;
      flags_q <= flags_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tcp_data_out   = data_q;
  assign tcp_data_valid = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
